// File: rtl/mc_mem_arbiter.sv
// Two-requester (CPU / DMA) arbiter and sequencer for the unified memory port.
// Alternating priority on contention, ready-handshake memory, timeout with err.
module mc_mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          gnt_cpu,
    output logic          gnt_dma,
    output logic          err,
    output logic [1:0]    fsm_state
);

    // Handshake: a requester holds req (with we/addr/wdata stable) until it
    // sees its one-cycle ack; memory completes an access in any ACCESS cycle
    // where mem_ready is high, and mem_ready is ignored in every other state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     state;
    logic       last_dma;
    logic [7:0] wait_cnt;
    logic       pick_cpu;
    logic       pick_dma;

    // On a tie the requester that did not win last time gets the port.
    assign pick_cpu  = cpu_req && (!dma_req || last_dma);
    assign pick_dma  = dma_req && !pick_cpu;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_dma  <= 1'b1;
            wait_cnt  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
            gnt_cpu   <= 1'b0;
            gnt_dma   <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_cpu || pick_dma) begin
                        mem_en    <= 1'b1;
                        mem_we    <= pick_cpu ? cpu_we    : dma_we;
                        mem_addr  <= pick_cpu ? cpu_addr  : dma_addr;
                        mem_wdata <= pick_cpu ? cpu_wdata : dma_wdata;
                        gnt_cpu   <= pick_cpu;
                        gnt_dma   <= pick_dma;
                        last_dma  <= pick_dma;
                        wait_cnt  <= '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (!mem_we) begin
                            if (gnt_cpu) cpu_rdata <= mem_rdata;
                            else         dma_rdata <= mem_rdata;
                        end
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        cpu_ack <= gnt_cpu;
                        dma_ack <= gnt_dma;
                        state   <= DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        if (gnt_cpu) cpu_rdata <= '0;
                        else         dma_rdata <= '0;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        cpu_ack <= gnt_cpu;
                        dma_ack <= gnt_dma;
                        err     <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    err     <= 1'b0;
                    gnt_cpu <= 1'b0;
                    gnt_dma <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_mem_arbiter.sv
// Scoreboard bench for mc_mem_arbiter: directed transactions, a scripted
// memory model, and a monitor that pops expected acks as they appear.
module tb_mc_mem_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int WAIT_MAX = 15;
    localparam int EW       = DW + 2;  // {is_dma, err, rdata}

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
    logic          cpu_ack, dma_ack;
    logic          mem_en, mem_we, mem_ready;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          gnt_cpu, gnt_dma, err;
    logic [1:0]    fsm_state;

    always #5 clk = ~clk;

    mc_mem_arbiter #(.AW(AW), .DW(DW), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .gnt_cpu(gnt_cpu), .gnt_dma(gnt_dma), .err(err), .fsm_state(fsm_state)
    );

    typedef struct packed {
        logic          noready;
        logic [7:0]    cycles;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } mem_cfg_t;

    mem_cfg_t      cfg_q[$];
    mem_cfg_t      cur;
    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] cpu_m, dma_m;
    logic          idle_pulse;
    logic          in_acc = 1'b0;
    int            mcnt = 0;
    logic          prev_ack = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    // Pushes the memory script and the expected ack for one granted access.
    task automatic expect_txn(input logic is_dma, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input int cycles,
                              input logic noready, input logic [DW-1:0] mdata);
        logic [DW-1:0] rd;
        cfg_q.push_back('{noready, 8'(cycles), we, addr, wdata, mdata});
        if (noready)  rd = '0;
        else if (!we) rd = mdata;
        else          rd = is_dma ? dma_m : cpu_m;
        if (is_dma) dma_m = rd;
        else        cpu_m = rd;
        exp_q.push_back({is_dma, noready, rd});
    endtask

    task automatic txn(input logic is_dma, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input int exp_lat);
        int   n = 0;
        logic done = 1'b0;
        @(negedge clk);
        if (is_dma) begin
            dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        end
        while (!done && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (is_dma ? dma_ack : cpu_ack) done = 1'b1;
        end
        if (!done)            fail(is_dma ? "dma_ack_timeout" : "cpu_ack_timeout");
        else if (exp_lat > 0) chk(is_dma ? "dma_latency" : "cpu_latency", 64'(n), 64'(exp_lat));
        @(posedge clk);
        #1;
        if (is_dma) dma_req = 1'b0;
        else        cpu_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, 64'({mem_en, mem_we, gnt_cpu, gnt_dma, cpu_ack, dma_ack, err, fsm_state}), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_cpu_rdata"}, 64'(cpu_rdata), 64'd0);
        chk({tag, "_dma_rdata"}, 64'(dma_rdata), 64'd0);
    endtask

    // Memory model: follows the scripted cycle count and checks stable drive.
    always @(negedge clk) begin
        if (mem_en) begin
            if (!in_acc) begin
                in_acc = 1'b1;
                mcnt   = 0;
                if (cfg_q.size() == 0) begin
                    fail("unexpected_mem_access");
                    cur = '0;
                    cur.noready = 1'b1;
                end else begin
                    cur = cfg_q.pop_front();
                end
            end
            chk("mem_we", 64'(mem_we), 64'(cur.we));
            chk("mem_addr", 64'(mem_addr), 64'(cur.addr));
            if (cur.we) chk("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
            mem_ready = !cur.noready && (mcnt == int'(cur.cycles) - 1);
            mem_rdata = cur.rdata;
            mcnt++;
        end else begin
            if (in_acc) begin
                chk("mem_cycles", 64'(mcnt), 64'(cur.cycles));
                in_acc = 1'b0;
            end
            mem_ready = idle_pulse;
            mem_rdata = '0;
        end
    end

    // Monitor: every ack must match the head of the expected queue.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (cpu_ack || dma_ack) begin
            if (prev_ack) fail("ack_longer_than_one_cycle");
            if (exp_q.size() == 0) begin
                fail("unexpected_ack");
            end else begin
                e = exp_q.pop_front();
                chk("ack_owner", 64'({dma_ack, cpu_ack}), 64'({e[EW-1], !e[EW-1]}));
                chk("gnt_owner", 64'({gnt_dma, gnt_cpu}), 64'({e[EW-1], !e[EW-1]}));
                chk("err", 64'(err), 64'(e[EW-2]));
                chk(e[EW-1] ? "dma_rdata" : "cpu_rdata", 64'(e[EW-1] ? dma_rdata : cpu_rdata), 64'(e[DW-1:0]));
            end
        end else if (err) begin
            fail("err_without_ack");
        end
        prev_ack = cpu_ack || dma_ack;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        idle_pulse = 1'b0;
        cpu_m = '0;
        dma_m = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single zero-wait reads, one per requester.
        expect_txn(1'b0, 1'b0, 32'h40, '0, 1, 1'b0, 32'hDEADBEEF);
        txn(1'b0, 1'b0, 32'h40, '0, 2);
        expect_txn(1'b1, 1'b0, 32'h80, '0, 1, 1'b0, 32'h0BADF00D);
        txn(1'b1, 1'b0, 32'h80, '0, 2);

        // Continuous contention: grants must alternate CPU, DMA, CPU, DMA.
        expect_txn(1'b0, 1'b0, 32'h10, '0, 1, 1'b0, 32'h11111111);
        expect_txn(1'b1, 1'b0, 32'h20, '0, 1, 1'b0, 32'h22222222);
        expect_txn(1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 1, 1'b0, 32'hFFFFFFFF);
        expect_txn(1'b1, 1'b0, 32'h24, '0, 1, 1'b0, 32'h33333333);
        fork
            begin
                txn(1'b0, 1'b0, 32'h10, '0, 0);
                txn(1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 0);
            end
            begin
                txn(1'b1, 1'b0, 32'h20, '0, 0);
                txn(1'b1, 1'b0, 32'h24, '0, 0);
            end
        join

        // DMA write with three wait cycles; dma_rdata must keep 0x33333333.
        expect_txn(1'b1, 1'b1, 32'h100, 32'h12345678, 4, 1'b0, 32'hFFFFFFFF);
        txn(1'b1, 1'b1, 32'h100, 32'h12345678, 5);

        // Memory never answers: timeout after WAIT_MAX ACCESS cycles.
        expect_txn(1'b0, 1'b0, 32'h200, '0, WAIT_MAX, 1'b1, 32'hFFFFFFFF);
        txn(1'b0, 1'b0, 32'h200, '0, WAIT_MAX + 1);
        @(negedge clk);
        chk("idle_after_timeout", 64'(fsm_state), 64'd0);

        // Reset in the second ACCESS cycle of a CPU read, DMA joins the contest.
        cfg_q.push_back('{1'b1, 8'd2, 1'b0, 32'h300, 32'h0, 32'h0});
        expect_txn(1'b0, 1'b0, 32'h300, '0, 1, 1'b0, 32'h5555AAAA);
        expect_txn(1'b1, 1'b0, 32'h304, '0, 2, 1'b0, 32'h66666666);
        fork
            txn(1'b0, 1'b0, 32'h300, '0, 0);
            begin
                int k = 0;
                @(negedge clk);
                while (!mem_en && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                if (!mem_en) fail("reset_test_no_access");
                @(negedge clk);
                rst = 1'b1;
                @(posedge clk);
                #1;
                check_reset_outputs("mid_access_reset");
                @(negedge clk);
                rst = 1'b0;
            end
            begin
                wait (rst);
                txn(1'b1, 1'b0, 32'h304, '0, 0);
            end
        join

        // mem_ready pulse while idle must be ignored.
        @(posedge clk);
        #1 idle_pulse = 1'b1;
        @(posedge clk);
        #1 idle_pulse = 1'b0;
        @(negedge clk);
        chk("idle_pulse_state", 64'(fsm_state), 64'd0);
        chk("idle_pulse_outputs", 64'({cpu_ack, dma_ack, err, mem_en, gnt_cpu, gnt_dma}), 64'd0);

        repeat (3) @(negedge clk);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("cfg_q_drained", 64'(cfg_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
